// File: rtl/serial_marker_pkg.sv
// Shared types and defaults for the serial marker transmitter and the "111" detector benches.
package serial_marker_pkg;

    localparam int MARK_LEN_D = 3;
    localparam int GAP_LEN_D  = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MARK  = 3'd1,
        S_SEP   = 3'd2,
        S_DATA  = 3'd3,
        S_STUFF = 3'd4,
        S_GAP   = 3'd5
    } state_e;

    // Plain-vector encodings for legacy FSM code that keeps state in logic [2:0].
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_MARK  = S_MARK;
    localparam logic [2:0] ST_SEP   = S_SEP;
    localparam logic [2:0] ST_DATA  = S_DATA;
    localparam logic [2:0] ST_STUFF = S_STUFF;
    localparam logic [2:0] ST_GAP   = S_GAP;

endpackage

// File: rtl/serial_marker_tx_if.sv
// Word-in / serial-out bus of serial_marker_tx; master is the word producer, slave the transmitter.
interface serial_marker_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              x_out;
    logic              tx_busy;
    logic              frame_done;

    modport master (output in_data, in_valid, input in_ready, x_out, tx_busy, frame_done);
    modport slave  (input in_data, in_valid, output in_ready, x_out, tx_busy, frame_done);
endinterface

// File: rtl/serial_stuffer.sv
// Payload run tracker: requests a stuffed zero once MARK_LEN-1 consecutive payload ones are emitted.
module serial_stuffer #(
    parameter int MARK_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_bit,
    output logic o_stuff
);
    localparam int              RUN_W    = $clog2(MARK_LEN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MARK_LEN - 2);

    logic [RUN_W-1:0] r_run;

    assign o_bit   = i_bit;
    assign o_stuff = i_bit && (r_run == RUN_LAST);

    // The run restarts on the stuff decision itself, since the stuffed zero follows immediately.
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_run <= '0;
        else if (i_shift)
            r_run <= (!i_bit || o_stuff) ? '0 : r_run + 1'b1;
    end
endmodule

// File: rtl/serial_marker_tx.sv
// Marker/zero-stuffed serial frame transmitter; `define SERIAL_MARKER_TX_PARITY_EN appends an even-parity bit.
module serial_marker_tx
    import serial_marker_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MARK_LEN = MARK_LEN_D,
    parameter int GAP_LEN  = GAP_LEN_D
) (
    input  logic               clk,
    input  logic               rst,
    serial_marker_tx_if.slave  bus
);
`ifdef SERIAL_MARKER_TX_PARITY_EN
    localparam int PAY_W = DATA_W + 1;
`else
    localparam int PAY_W = DATA_W;
`endif
    localparam int IDX_W   = $clog2(PAY_W + 1);
    localparam int MCNT_W  = $clog2(MARK_LEN + 1);
    localparam int GAP_W   = $clog2(GAP_LEN + 1);
    localparam bit GAP_ONE = (GAP_LEN == 1);

    logic [2:0]       r_state;
    logic [PAY_W-1:0] r_sr;
    logic [IDX_W-1:0] r_idx;
    logic [MCNT_W-1:0] r_mcnt;
    logic [GAP_W-1:0] r_gcnt;
    logic             r_stuff_pend;
    logic             r_x;
    logic             r_busy;
    logic             r_done;

    logic             w_xfer;
    logic             w_last;
    logic             w_emit;
    logic             w_bit;
    logic             w_stuff;
    logic [PAY_W-1:0] w_word;

`ifdef SERIAL_MARKER_TX_PARITY_EN
    assign w_word = {bus.in_data, ^bus.in_data};
`else
    assign w_word = bus.in_data;
`endif

    assign bus.in_ready   = (r_state == ST_IDLE) && !rst;
    assign bus.x_out      = r_x;
    assign bus.tx_busy    = r_busy;
    assign bus.frame_done = r_done;

    assign w_xfer = bus.in_valid && bus.in_ready;
    assign w_last = (r_idx == IDX_W'(PAY_W));
    // r_state names the symbol currently on the line; w_emit means the next symbol is a payload bit.
    assign w_emit = (r_state == ST_SEP)
                 || ((r_state == ST_DATA) && !r_stuff_pend && !w_last)
                 || ((r_state == ST_STUFF) && !w_last);

    serial_stuffer #(.MARK_LEN(MARK_LEN)) u_stuffer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_xfer),
        .i_shift (w_emit),
        .i_bit   (r_sr[PAY_W-1]),
        .o_bit   (w_bit),
        .o_stuff (w_stuff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_idx        <= '0;
            r_mcnt       <= '0;
            r_gcnt       <= '0;
            r_stuff_pend <= 1'b0;
            r_x          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_emit) begin
                r_state      <= ST_DATA;
                r_x          <= w_bit;
                r_sr         <= r_sr << 1;
                r_idx        <= r_idx + 1'b1;
                r_stuff_pend <= w_stuff;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_xfer) begin
                            r_state <= ST_MARK;
                            r_sr    <= w_word;
                            r_idx   <= '0;
                            r_mcnt  <= MCNT_W'(1);
                            r_x     <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_MARK: begin
                        if (r_mcnt == MCNT_W'(MARK_LEN)) begin
                            r_state <= ST_SEP;
                            r_x     <= 1'b0;
                        end else begin
                            r_mcnt <= r_mcnt + 1'b1;
                        end
                    end
                    ST_DATA, ST_STUFF: begin
                        r_x <= 1'b0;
                        if ((r_state == ST_DATA) && r_stuff_pend) begin
                            r_state      <= ST_STUFF;
                            r_stuff_pend <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                            r_gcnt  <= GAP_W'(1);
                            r_done  <= GAP_ONE;
                        end
                    end
                    ST_GAP: begin
                        if (r_gcnt == GAP_W'(GAP_LEN)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gcnt <= r_gcnt + 1'b1;
                            r_done <= (r_gcnt == GAP_W'(GAP_LEN - 1));
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_x     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_marker_tx.sv
// Directed bench for serial_marker_tx (DATA_W=8, MARK_LEN=3, GAP_LEN=1).
module tb_serial_marker_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_marker_tx_if #(.DATA_W(8)) bus ();

    serial_marker_tx #(.DATA_W(8), .MARK_LEN(3), .GAP_LEN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: drop valid after transfer; 1: hold valid and present nd; 2: scramble inputs while busy.
    task automatic frame(input logic [7:0] d, input logic [31:0] exp, input int len,
                         input int mode, input logic [7:0] nd, input string tag);
        int n;
        int run;
        int hits;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, " ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        if (mode == 1) bus.in_data = nd;
        else           bus.in_valid = 1'b0;
        run  = 0;
        hits = 0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s x%0d", tag, i),    32'(bus.x_out),      32'(exp[len-1-i]));
            chk($sformatf("%s busy%0d", tag, i), 32'(bus.tx_busy),    32'd1);
            chk($sformatf("%s done%0d", tag, i), 32'(bus.frame_done), 32'(i == len - 1));
            chk($sformatf("%s rdy%0d", tag, i),  32'(bus.in_ready),   32'd0);
            if (bus.x_out) begin
                run++;
                if (run >= 3) hits++;
            end else begin
                run = 0;
            end
            if (mode == 2) begin
                bus.in_data  = 8'(i * 37 + 1);
                bus.in_valid = 1'(i);
            end
            step();
        end
        if (mode == 2) bus.in_valid = 1'b0;
        chk({tag, " idle_busy"}, 32'(bus.tx_busy),    32'd0);
        chk({tag, " idle_x"},    32'(bus.x_out),      32'd0);
        chk({tag, " idle_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, " idle_rdy"},  32'(bus.in_ready),   32'd1);
        chk({tag, " det111"},    32'(hits),           32'd1);
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(bus.in_ready),   32'd0);
        chk("rst_x",     32'(bus.x_out),      32'd0);
        chk("rst_busy",  32'(bus.tx_busy),    32'd0);
        chk("rst_done",  32'(bus.frame_done), 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_x",     32'(bus.x_out),    32'd0);

`ifdef SERIAL_MARKER_TX_PARITY_EN
        frame(8'h03, 32'(15'b1110_0000001100_0), 15, 0, 8'h00, "par03");
`else
        frame(8'hA5, 32'(13'b1110_10100101_0), 13, 0, 8'h00, "A5");
        frame(8'hFF, 32'(17'b1110_110110110110_0), 17, 0, 8'h00, "FF");
        frame(8'h00, 32'(13'b1110_00000000_0), 13, 1, 8'h0F, "00held");
        frame(8'h0F, 32'(15'b1110_0000110110_0), 15, 0, 8'h00, "0F");

        // Abort an 0xFF frame on its 6th cycle.
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_pre_x",    32'(bus.x_out),   32'd1);
        chk("abort_pre_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b1;
        chk("abort_rst_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("abort_x",    32'(bus.x_out),      32'd0);
        chk("abort_busy", 32'(bus.tx_busy),    32'd0);
        chk("abort_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        step();
        chk("abort_idle_done", 32'(bus.frame_done), 32'd0);
        step();
        frame(8'hFF, 32'(17'b1110_110110110110_0), 17, 0, 8'h00, "FFre");

        frame(8'h3C, 32'(15'b1110_0011011000_0), 15, 2, 8'h00, "3Cscr");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
